hilo_muldiv_ctrl: RTL and testbench

Multi-cycle multiply/divide controller that owns the HI/LO write path of the register file. It accepts MULT/MULTU/DIV/DIVU from the EX stage and runs one shared iterative shift-add/restoring-subtract engine over 32 iterations. It holds the pipeline with a stall request while busy, then presents a single-cycle HI/LO write (data plus both write enables) to the EX→MEM path. It sits beside the EX ALU; its hi/lo outputs feed the same forwarding/write ports as other HI/LO writers.

---
 rtl/hilo_muldiv_ctrl_pkg.sv | 27 ++
 rtl/hilo_muldiv_ctrl_if.sv | 27 ++
 rtl/hilo_muldiv_ctrl_muldiv_iter.sv | 39 +++
 rtl/hilo_muldiv_ctrl.sv | 141 ++++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared types and constants for the HI/LO multiply/divide controller.
// Op encoding: bit1 selects divide, bit0 selects unsigned.
package hilo_muldiv_ctrl_pkg;

    localparam int MD_ITER = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    function automatic logic [31:0] md_abs(
        input logic [31:0] v,
        input logic        sgn
    );
        return (sgn && v[31]) ? -v : v;
    endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// EX-stage request / HI-LO write bundle for the mul/div controller.
// master = EX pipeline side, slave = the controller.
interface hilo_muldiv_ctrl_if;

    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall_req;
    logic        done;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport master (
        output start, op, src_a, src_b, flush,
        input  stall_req, done, hi_we, lo_we, hi_o, lo_o
    );

    modport slave (
        input  start, op, src_a, src_b, flush,
        output stall_req, done, hi_we, lo_we, hi_o, lo_o
    );

endinterface

// File: rtl/hilo_muldiv_ctrl_muldiv_iter.sv
// One shift-add (mul) or restoring-subtract (div) step of the engine.
// Div: acc holds the partial remainder, y the dividend/quotient bits.
module muldiv_iter #(
    parameter int W = 32
) (
    input  logic           is_div,
    input  logic [2*W-1:0] acc,
    input  logic [2*W-1:0] x,
    input  logic [W-1:0]   y,
    output logic [2*W-1:0] acc_n,
    output logic [2*W-1:0] x_n,
    output logic [W-1:0]   y_n
);

    logic [W:0]   sh;
    logic [W+1:0] diff;
    logic         borrow;

    assign sh     = {acc[W-1:0], y[W-1]};
    assign diff   = {1'b0, sh} - {2'b00, x[W-1:0]};
    assign borrow = diff[W+1];

    always_comb begin
        acc_n = acc;
        x_n   = x;
        y_n   = y;
        if (is_div) begin
            acc_n = {{(W-1){1'b0}}, (borrow ? sh : diff[W:0])};
            y_n   = {y[W-2:0], ~borrow};
        end else begin
            if (y[0]) begin
                acc_n = acc + x;
            end
            x_n = x << 1;
            y_n = y >> 1;
        end
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU controller owning the HI/LO write path.
// Stalls the pipeline while busy, then emits a one-cycle HI/LO write.
module hilo_muldiv_ctrl
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int ITER = MD_ITER
) (
    input logic               clk,
    input logic               resetn,
    hilo_muldiv_ctrl_if.slave bus
);

    localparam int W  = 32;
    localparam int CW = $clog2(ITER);

    md_state_t   state, state_n;
    logic [CW-1:0] cnt;
    logic [1:0]  op_q;
    logic [W-1:0] a_q, b_q;
    logic [2*W-1:0] acc, x, acc_n, x_n;
    logic [W-1:0] y, y_n;
    logic [W-1:0] hi_q, lo_q;
    logic        done, stall;

    logic        accept;
    logic [W-1:0] a_mag, b_mag;

    assign accept = bus.start && !bus.flush;
    assign a_mag  = md_abs(bus.src_a, ~bus.op[0]);
    assign b_mag  = md_abs(bus.src_b, ~bus.op[0]);

    muldiv_iter #(.W(W)) u_iter (
        .is_div (op_q[1]),
        .acc    (acc),
        .x      (x),
        .y      (y),
        .acc_n  (acc_n),
        .x_n    (x_n),
        .y_n    (y_n)
    );

    // Sign fix-up on the final engine output; div-by-zero bypasses it.
    logic           sgn, neg_q, neg_r, div0;
    logic [2*W-1:0] prod_f;
    logic [W-1:0]   quot_f, rem_f;
    logic [W-1:0]   res_hi, res_lo;

    assign sgn    = ~op_q[0];
    assign neg_q  = sgn && (a_q[W-1] ^ b_q[W-1]);
    assign neg_r  = sgn && a_q[W-1];
    assign div0   = (b_q == '0);
    assign prod_f = neg_q ? -acc_n : acc_n;
    assign quot_f = neg_q ? -y_n : y_n;
    assign rem_f  = neg_r ? -acc_n[W-1:0] : acc_n[W-1:0];

    always_comb begin
        res_hi = prod_f[2*W-1:W];
        res_lo = prod_f[W-1:0];
        if (op_q[1]) begin
            res_hi = div0 ? a_q : rem_f;
            res_lo = div0 ? {W{1'b1}} : quot_f;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= MD_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        done    = 1'b0;
        stall   = 1'b0;
        unique case (state)
            MD_IDLE: begin
                if (accept) begin
                    state_n = MD_BUSY;
                    stall   = 1'b1;
                end
            end
            MD_BUSY: begin
                stall = 1'b1;
                if (cnt == '0) begin
                    state_n = MD_DONE;
                end
            end
            MD_DONE: begin
                done    = 1'b1;
                state_n = MD_IDLE;
            end
            default: state_n = MD_IDLE;
        endcase
        if (bus.flush) begin
            state_n = MD_IDLE;
            done    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt  <= '0;
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            acc  <= '0;
            x    <= '0;
            y    <= '0;
            hi_q <= '0;
            lo_q <= '0;
        end else if (state == MD_IDLE && accept) begin
            cnt  <= CW'(ITER - 1);
            op_q <= bus.op;
            a_q  <= bus.src_a;
            b_q  <= bus.src_b;
            acc  <= '0;
            x    <= {{W{1'b0}}, (bus.op[1] ? b_mag : a_mag)};
            y    <= bus.op[1] ? a_mag : b_mag;
        end else if (state == MD_BUSY && !bus.flush) begin
            acc <= acc_n;
            x   <= x_n;
            y   <= y_n;
            if (cnt == '0) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign bus.stall_req = stall;
    assign bus.done      = done;
    assign bus.hi_we     = done;
    assign bus.lo_we     = done;
    assign bus.hi_o      = hi_q;
    assign bus.lo_o      = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed-vector bench for hilo_muldiv_ctrl.
// Inputs driven and outputs sampled around the falling edge.
module tb_hilo_muldiv_ctrl;
    import hilo_muldiv_ctrl_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hilo_muldiv_ctrl_if bus ();

    hilo_muldiv_ctrl #(.ITER(MD_ITER)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // Issue one op at cycle 0 and observe 40 following cycles.
    task automatic run_op(
        input  logic [1:0]  op,
        input  logic [31:0] a,
        input  logic [31:0] b,
        output int          dc,
        output int          sc,
        output int          pulses,
        output logic [31:0] hi,
        output logic [31:0] lo,
        output logic        we_ok,
        output logic        hold_ok
    );
        logic [31:0] hi0, lo0;
        dc = -1; sc = 0; pulses = 0;
        hi = '0; lo = '0; we_ok = 1'b0; hold_ok = 1'b1;
        @(negedge clk);
        hi0 = bus.hi_o;
        lo0 = bus.lo_o;
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        #1;
        if (bus.stall_req) sc++;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            #1;
            if (bus.stall_req) sc++;
            if (c < 33 && (bus.hi_o !== hi0 || bus.lo_o !== lo0))
                hold_ok = 1'b0;
            if (bus.done) begin
                pulses++;
                if (dc < 0) begin
                    dc = c;
                    hi = bus.hi_o;
                    lo = bus.lo_o;
                    we_ok = bus.hi_we && bus.lo_we;
                end
            end
        end
    endtask

    task automatic test_reset;
        resetn    = 1'b0;
        bus.start = 1'b0;
        bus.flush = 1'b1;
        bus.op    = MD_MULT;
        bus.src_a = '0;
        bus.src_b = '0;
        repeat (3) @(negedge clk);
        bus.flush = 1'b0;
        #1;
        checks++;
        if ({bus.stall_req, bus.done, bus.hi_we, bus.lo_we} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000",
                     {bus.stall_req, bus.done, bus.hi_we, bus.lo_we});
        end
        checks++;
        if (bus.hi_o !== 32'h0 || bus.lo_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_hilo: got %h_%h expected 0", bus.hi_o, bus.lo_o);
        end
        resetn = 1'b1;
    endtask

    task automatic test_mult;
        int dc, sc, p; logic [31:0] hi, lo; logic we, hold;
        run_op(MD_MULT, 32'hFFFFFFFE, 32'd3, dc, sc, p, hi, lo, we, hold);
        checks++;
        if (dc !== 33) begin
            errors++; $display("FAIL mult_latency: got %0d expected 33", dc);
        end
        checks++;
        if (sc !== 33) begin
            errors++; $display("FAIL mult_stall_cycles: got %0d expected 33", sc);
        end
        checks++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
            errors++;
            $display("FAIL mult_result: got %h_%h expected ffffffff_fffffffa", hi, lo);
        end
        checks++;
        if (!hold) begin
            errors++; $display("FAIL mult_hold: hi/lo changed before done, expected hold");
        end
    endtask

    task automatic test_multu;
        int dc, sc, p; logic [31:0] hi, lo; logic we, hold;
        run_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, dc, sc, p, hi, lo, we, hold);
        checks++;
        if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
            errors++;
            $display("FAIL multu_result: got %h_%h expected fffffffe_00000001", hi, lo);
        end
        checks++;
        if (we !== 1'b1 || p !== 1) begin
            errors++; $display("FAIL multu_we: got we=%b pulses=%0d expected 1/1", we, p);
        end
    endtask

    task automatic test_div;
        int dc, sc, p; logic [31:0] hi, lo; logic we, hold;
        run_op(MD_DIV, 32'hFFFFFFF9, 32'd2, dc, sc, p, hi, lo, we, hold);
        checks++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
            errors++;
            $display("FAIL div_neg: got %h_%h expected ffffffff_fffffffd", hi, lo);
        end
        run_op(MD_DIVU, 32'd100, 32'd7, dc, sc, p, hi, lo, we, hold);
        checks++;
        if (hi !== 32'd2 || lo !== 32'd14 || dc !== 33) begin
            errors++;
            $display("FAIL divu_100_7: got %h_%h at %0d expected 2_14 at 33", hi, lo, dc);
        end
        run_op(MD_DIV, 32'd20, 32'hFFFFFFFD, dc, sc, p, hi, lo, we, hold);
        checks++;
        if (hi !== 32'd2 || lo !== 32'hFFFFFFFA) begin
            errors++;
            $display("FAIL div_negdiv: got %h_%h expected 2_fffffffa", hi, lo);
        end
    endtask

    task automatic test_div_zero;
        int dc, sc, p; logic [31:0] hi, lo; logic we, hold;
        run_op(MD_DIVU, 32'd7, 32'd0, dc, sc, p, hi, lo, we, hold);
        checks++;
        if (hi !== 32'd7 || lo !== 32'hFFFFFFFF || dc !== 33) begin
            errors++;
            $display("FAIL divu_zero: got %h_%h at %0d expected 7_ffffffff at 33", hi, lo, dc);
        end
        run_op(MD_DIV, 32'hFFFFFFF9, 32'd0, dc, sc, p, hi, lo, we, hold);
        checks++;
        if (hi !== 32'hFFFFFFF9 || lo !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL div_zero_signed: got %h_%h expected fffffff9_ffffffff", hi, lo);
        end
    endtask

    task automatic test_div_overflow;
        int dc, sc, p; logic [31:0] hi, lo; logic we, hold;
        run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, dc, sc, p, hi, lo, we, hold);
        checks++;
        if (hi !== 32'h0 || lo !== 32'h80000000) begin
            errors++;
            $display("FAIL div_overflow: got %h_%h expected 0_80000000", hi, lo);
        end
    endtask

    task automatic test_flush;
        int dc, sc, p; logic [31:0] hi, lo, hi0, lo0; logic we, hold;
        @(negedge clk);
        hi0 = bus.hi_o;
        lo0 = bus.lo_o;
        bus.start = 1'b1;
        bus.op    = MD_DIVU;
        bus.src_a = 32'd100;
        bus.src_b = 32'd7;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (c == 10) bus.flush = 1'b1;
        end
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        checks++;
        if (bus.stall_req !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: got stall=%b done=%b expected 0/0",
                     bus.stall_req, bus.done);
        end
        checks++;
        if (bus.hi_o !== hi0 || bus.lo_o !== lo0) begin
            errors++;
            $display("FAIL flush_hold: got %h_%h expected %h_%h",
                     bus.hi_o, bus.lo_o, hi0, lo0);
        end
        run_op(MD_MULT, 32'd5, 32'd6, dc, sc, p, hi, lo, we, hold);
        checks++;
        if (dc !== 33 || hi !== 32'd0 || lo !== 32'd30) begin
            errors++;
            $display("FAIL flush_next_mult: got %h_%h at %0d expected 0_30 at 33", hi, lo, dc);
        end
        checks++;
        if (p !== 1) begin
            errors++; $display("FAIL flush_no_done: got %0d pulses expected 1", p);
        end
    endtask

    task automatic test_reset_mid;
        int p;
        p = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = MD_MULTU;
        bus.src_a = 32'd3;
        bus.src_b = 32'd3;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (c == 20) resetn = 1'b0;
        end
        @(negedge clk);
        resetn = 1'b1;
        #1;
        checks++;
        if (bus.hi_o !== 32'h0 || bus.lo_o !== 32'h0 || bus.stall_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got %h_%h stall=%b expected 0_0 stall=0",
                     bus.hi_o, bus.lo_o, bus.stall_req);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (bus.done) p++;
        end
        checks++;
        if (p !== 0) begin
            errors++; $display("FAIL reset_mid_done: got %0d pulses expected 0", p);
        end
    endtask

    task automatic test_flush_done;
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = MD_MULTU;
        bus.src_a = 32'd7;
        bus.src_b = 32'd6;
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            #1;
            if (c == 33) seen = bus.done;
        end
        bus.flush = 1'b1;
        #1;
        checks++;
        if (!seen || {bus.done, bus.hi_we, bus.lo_we} !== 3'b000) begin
            errors++;
            $display("FAIL flush_done: got pre=%b we=%b expected pre=1 we=000",
                     seen, {bus.done, bus.hi_we, bus.lo_we});
        end
        checks++;
        if (bus.lo_o !== 32'd42 || bus.hi_o !== 32'd0) begin
            errors++;
            $display("FAIL flush_done_data: got %h_%h expected 0_2a", bus.hi_o, bus.lo_o);
        end
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        checks++;
        if (bus.stall_req !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL flush_done_after: got stall=%b done=%b expected 0/0",
                     bus.stall_req, bus.done);
        end
    endtask

    task automatic test_back_to_back;
        int dc;
        dc = -1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = MD_MULTU;
        bus.src_a = 32'd2;
        bus.src_b = 32'd3;
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = MD_DIVU;
        bus.src_a = 32'd100;
        bus.src_b = 32'd7;
        #1;
        checks++;
        if (bus.done !== 1'b1 || bus.stall_req !== 1'b0 || bus.lo_o !== 32'd6) begin
            errors++;
            $display("FAIL b2b_done_cycle: got done=%b stall=%b lo=%h expected 1/0/6",
                     bus.done, bus.stall_req, bus.lo_o);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.stall_req !== 1'b1) begin
            errors++; $display("FAIL b2b_accept: got stall=%b expected 1", bus.stall_req);
        end
        for (int c = 35; c <= 75; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            #1;
            if (bus.done && dc < 0) dc = c;
        end
        checks++;
        if (dc !== 67 || bus.hi_o !== 32'd2 || bus.lo_o !== 32'd14) begin
            errors++;
            $display("FAIL b2b_second: got done at %0d %h_%h expected 67 2_e",
                     dc, bus.hi_o, bus.lo_o);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_div_zero();
        test_div_overflow();
        test_flush();
        test_reset_mid();
        test_flush_done();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
